alu_mc: RTL

Parametrised multi-cycle ALU, the W-bit successor to the 8-bit combinational ALP in the multi-cycle CPU datapath. It keeps ALP's opcode encoding and adds iterative shifts and rotates (one bit per cycle) and a shift-add unsigned multiply. It registers the result and the C_out/OVF/Z/N flags, and adds a start/busy/done handshake so the CPU control FSM can stall on long operations.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_mc_core.sv | 44 ++++
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and iteration-count helper for the
// multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_CLR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_LSL = 4'b0111;
    localparam logic [3:0] OP_ASR = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic {IDLE, EXEC} state_t;

    // Number of EXEC cycles for an operation; zero-step shifts/rotates still take one.
    function automatic int iter_count(input logic [3:0] op, input logic [63:0] b, input int w);
        logic [63:0] wl;
        logic [63:0] k;
        wl = 64'(w);
        case (op)
            OP_LSR, OP_LSL, OP_ASR: k = (b >= wl) ? wl : b;
            OP_ROR, OP_ROL:         k = b % wl;
            OP_MUL:                 k = wl;
            default:                k = 64'd1;
        endcase
        if (k == 64'd0) begin
            k = 64'd1;
        end
        return int'(k[31:0]);
    endfunction

endpackage

// File: rtl/alu_mc_core.sv
// Single-cycle ALU slice: add/sub, bitwise ops, clear and the reserved opcodes.
// Anything it does not handle yields zero result and zero flags.
module alu_mc_core
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] f_o,
    output logic         c_o,
    output logic         ovf_o
);

    logic [W:0] sum;

    always_comb begin
        f_o   = '0;
        c_o   = 1'b0;
        ovf_o = 1'b0;
        sum   = '0;
        case (op_i)
            OP_ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                f_o   = sum[W-1:0];
                c_o   = sum[W];
                ovf_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is the "no borrow" flag (A >= B unsigned).
                sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
                f_o   = sum[W-1:0];
                c_o   = sum[W];
                ovf_o = (a_i[W-1] != b_i[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_AND:  f_o = a_i & b_i;
            OP_OR:   f_o = a_i | b_i;
            OP_XOR:  f_o = a_i ^ b_i;
            default: f_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: start/busy/done handshake, iterative shifts/rotates,
// shift-add multiply, and registered result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   I,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] F,
    output logic         C_out,
    output logic         OVF,
    output logic         Z,
    output logic         N,
    output logic         busy,
    output logic         done
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, n_init;
    logic          accept, last;

    logic [3:0]    op_q;
    logic [W-1:0]  a_q, b_q, wr_q, acc_q;
    logic          noshift_q, noshift_d;

    logic [W-1:0]  step_wr, step_acc, addend;
    logic [W:0]    mul_sum;
    logic          step_c;

    logic [W-1:0]  core_f;
    logic          core_c, core_ovf;
    logic [W-1:0]  res_f;
    logic          res_c, res_ovf;

    logic [W-1:0]  f_q;
    logic          c_q, ovf_q, z_q, n_q, done_q;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == EXEC) && (cnt_q == CW'(1));
    assign n_init = CW'(iter_count(I, 64'(B), W));

    always_comb begin
        noshift_d = 1'b0;
        case (I)
            OP_LSR, OP_LSL, OP_ASR: noshift_d = (B == '0);
            OP_ROR, OP_ROL:         noshift_d = ((64'(B) % 64'(W)) == 64'd0);
            default:                noshift_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                    cnt_d   = n_init;
                end
            end
            EXEC: begin
                if (last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One step of the iterative datapath; the final step feeds the result
    // registers directly so completion lands on edge t+n.
    always_comb begin
        step_wr  = wr_q;
        step_acc = acc_q;
        step_c   = 1'b0;
        addend   = wr_q[0] ? a_q : '0;
        mul_sum  = {1'b0, acc_q} + {1'b0, addend};
        case (op_q)
            OP_LSR: begin
                step_wr = {1'b0, wr_q[W-1:1]};
                step_c  = wr_q[0];
            end
            OP_LSL: begin
                step_wr = {wr_q[W-2:0], 1'b0};
                step_c  = wr_q[W-1];
            end
            OP_ASR: begin
                step_wr = {wr_q[W-1], wr_q[W-1:1]};
                step_c  = wr_q[0];
            end
            OP_ROR:  step_wr = {wr_q[0], wr_q[W-1:1]};
            OP_ROL:  step_wr = {wr_q[W-2:0], wr_q[W-1]};
            OP_MUL: begin
                step_acc = mul_sum[W:1];
                step_wr  = {mul_sum[0], wr_q[W-1:1]};
            end
            default: step_wr = wr_q;
        endcase
    end

    alu_mc_core #(.W(W)) u_core (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .f_o   (core_f),
        .c_o   (core_c),
        .ovf_o (core_ovf)
    );

    always_comb begin
        res_f   = core_f;
        res_c   = core_c;
        res_ovf = core_ovf;
        case (op_q)
            OP_LSR, OP_LSL, OP_ASR, OP_ROR, OP_ROL: begin
                res_ovf = 1'b0;
                res_f   = noshift_q ? wr_q : step_wr;
                res_c   = noshift_q ? 1'b0 : step_c;
            end
            OP_MUL: begin
                res_f   = step_wr;
                res_c   = |step_acc;
                res_ovf = 1'b0;
            end
            default: res_f = core_f;
        endcase
    end

    // Working registers: loaded on accept, advanced on every non-final EXEC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= I;
            a_q       <= A;
            b_q       <= B;
            wr_q      <= (I == OP_MUL) ? B : A;
            acc_q     <= '0;
            noshift_q <= noshift_d;
        end else if ((state_q == EXEC) && !last) begin
            wr_q  <= step_wr;
            acc_q <= step_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= '0;
            c_q    <= 1'b0;
            ovf_q  <= 1'b0;
            z_q    <= 1'b1;
            n_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                f_q   <= res_f;
                c_q   <= res_c;
                ovf_q <= res_ovf;
                z_q   <= (res_f == '0);
                n_q   <= res_f[W-1];
            end
        end
    end

    assign F     = f_q;
    assign C_out = c_q;
    assign OVF   = ovf_q;
    assign Z     = z_q;
    assign N     = n_q;
    assign busy  = (state_q == EXEC);
    assign done  = done_q;

endmodule
